// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle radix-2 restoring divider sequencer for DIV.W/DIV.WU/MOD.W/MOD.WU.
// Optional build macro DIV_EARLY_OUT_EN: finish immediately when |a| < |b|.
module div_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       stall,
  input  logic             flush,
  input  logic             div_en,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             ready,
  output logic             stallreq_for_div
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ZERO = 2'd1,
    ON   = 2'd2,
    END  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dvd_abs, dvs_abs, rem, quo;
  logic             sign_a, sign_b, sgn_flag;

  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
    return (~x) + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic en);
    return en ? neg(x) : x;
  endfunction

  logic signed [WIDTH-1:0] a_sgn, b_sgn;
  logic                    in_neg_a, in_neg_b;
  logic [WIDTH-1:0]        in_abs_a, in_abs_b;

  assign a_sgn    = a;
  assign b_sgn    = b;
  assign in_neg_a = signed_div & a_sgn[WIDTH-1];
  assign in_neg_b = signed_div & b_sgn[WIDTH-1];
  assign in_abs_a = cond_neg(a, in_neg_a);
  assign in_abs_b = cond_neg(b, in_neg_b);

  logic early;
`ifdef DIV_EARLY_OUT_EN
  assign early = (b != '0) && (in_abs_a < in_abs_b);
`else
  assign early = 1'b0;
`endif

  // One restoring step: the trial value keeps the bit shifted out of rem, so wide divisors work.
  logic [WIDTH:0]   trial;
  logic [WIDTH+1:0] diff;
  logic             take;
  logic [WIDTH-1:0] rem_step, quo_step, q_fix, r_fix, orig_a;

  assign trial    = {rem, quo[WIDTH-1]};
  assign diff     = {1'b0, trial} - {2'b00, dvs_abs};
  assign take     = ~diff[WIDTH+1];
  assign rem_step = take ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_step = {quo[WIDTH-2:0], take};
  assign q_fix    = cond_neg(quo_step, sgn_flag & (sign_a ^ sign_b));
  assign r_fix    = cond_neg(rem_step, sgn_flag & sign_a);
  assign orig_a   = cond_neg(dvd_abs, sign_a);

  logic unused_bits;
  assign unused_bits = ^{stall[5:3], stall[1:0], diff[WIDTH]};

  assign stallreq_for_div = div_en & ~ready;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (div_en) begin
          if (b == '0)  state_nxt = ZERO;
          else if (early) state_nxt = END;
          else          state_nxt = ON;
        end
      end
      ZERO:    state_nxt = END;
      ON:      if (cnt == LAST) state_nxt = END;
      END:     if (!stall[2]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      dvd_abs   <= '0;
      dvs_abs   <= '0;
      rem       <= '0;
      quo       <= '0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      sgn_flag  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      ready     <= 1'b0;
    end else if (flush) begin
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (div_en) begin
            dvd_abs  <= in_abs_a;
            dvs_abs  <= in_abs_b;
            sign_a   <= in_neg_a;
            sign_b   <= in_neg_b;
            sgn_flag <= signed_div;
            rem      <= '0;
            quo      <= in_abs_a;
            cnt      <= '0;
            if (early) begin
              quotient  <= '0;
              remainder <= a;
              ready     <= 1'b1;
            end
          end
        end
        ZERO: begin
          quotient  <= '1;
          remainder <= orig_a;
          ready     <= 1'b1;
        end
        ON: begin
          rem <= rem_step;
          quo <= quo_step;
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            quotient  <= q_fix;
            remainder <= r_fix;
            ready     <= 1'b1;
          end
        end
        END: begin
          if (!stall[2]) ready <= 1'b0;
        end
        default: ready <= 1'b0;
      endcase
    end
  end

endmodule
